// File: rtl/writeback_regfile_pkg.sv
// Shared CPU definitions for the writeback stage and the register file.
package writeback_regfile_pkg;

    localparam int CPU_DATA_W   = 32;
    localparam int CPU_NUM_REGS = 32;
    localparam int REG_ADDR_W   = 5;

    localparam logic [REG_ADDR_W-1:0] ZERO_REG = '0;

    // A writeback only commits when enabled and aimed at a real register.
    function automatic logic is_live_write(input logic                  we,
                                           input logic [REG_ADDR_W-1:0] rd);
        return we && (rd != ZERO_REG);
    endfunction

endpackage

// File: rtl/regfile_array.sv
// Raw register storage: one write port, two combinational read ports.
// No zero-register or bypass handling here; the writeback stage owns that.
module regfile_array
    import writeback_regfile_pkg::*;
#(
    parameter int DATA_W   = CPU_DATA_W,
    parameter int NUM_REGS = CPU_NUM_REGS
) (
    input  logic                  clk_i,
    input  logic                  rst_i,
    input  logic                  we_i,
    input  logic [REG_ADDR_W-1:0] waddr_i,
    input  logic [DATA_W-1:0]     wdata_i,
    input  logic [REG_ADDR_W-1:0] raddr_a_i,
    input  logic [REG_ADDR_W-1:0] raddr_b_i,
    output logic [DATA_W-1:0]     rdata_a_o,
    output logic [DATA_W-1:0]     rdata_b_o
);

    logic [DATA_W-1:0] mem_q [NUM_REGS];

    // Storage update; reset clears every entry immediately.
    // NOTE: this array is deliberately reset (architectural state must read 0
    // straight out of reset), so it maps to flops rather than a RAM macro.
    always_ff @(posedge clk_i or negedge rst_i) begin
        if (!rst_i) begin
            for (int i = 0; i < NUM_REGS; i++) begin
                mem_q[i] <= '0;
            end
        end else if (we_i && (int'(waddr_i) < NUM_REGS)) begin
            // NOTE: non-blocking so every flop samples pre-edge values.
            mem_q[waddr_i] <= wdata_i;
        end
    end

    // Asynchronous reads; addresses beyond NUM_REGS return 0.
    always_comb begin
        // NOTE: defaults first so no path through the block infers a latch.
        rdata_a_o = '0;
        rdata_b_o = '0;
        if (int'(raddr_a_i) < NUM_REGS) rdata_a_o = mem_q[raddr_a_i];
        if (int'(raddr_b_i) < NUM_REGS) rdata_b_o = mem_q[raddr_b_i];
    end

endmodule

// File: rtl/writeback_regfile.sv
// Writeback stage plus architectural register file: selects the writeback
// value, commits it, forwards it to same-cycle readers and counts retirements.
module writeback_regfile
    import writeback_regfile_pkg::*;
#(
    parameter int DATA_W   = CPU_DATA_W,
    parameter int NUM_REGS = CPU_NUM_REGS
) (
    input  logic                  clk_i,
    input  logic                  rst_i,
    input  logic                  RegWrite_i,
    input  logic                  MemtoReg_i,
    input  logic [DATA_W-1:0]     Data1_i,
    input  logic [DATA_W-1:0]     Data2_i,
    input  logic [REG_ADDR_W-1:0] RDaddr_i,
    input  logic [REG_ADDR_W-1:0] RSaddr_i,
    input  logic [REG_ADDR_W-1:0] RTaddr_i,
    output logic [DATA_W-1:0]     RSdata_o,
    output logic [DATA_W-1:0]     RTdata_o,
    output logic [DATA_W-1:0]     WBdata_o,
    output logic                  WBvalid_o,
    output logic [31:0]           retire_cnt_o
);

    logic [DATA_W-1:0] wb_data;
    logic              wb_valid;
    logic [DATA_W-1:0] raw_rs;
    logic [DATA_W-1:0] raw_rt;
    logic [31:0]       retire_cnt_q;
    logic [31:0]       retire_cnt_d;

    // Writeback source select and commit qualification.
    always_comb begin
        wb_data  = MemtoReg_i ? Data2_i : Data1_i;
        wb_valid = is_live_write(RegWrite_i, RDaddr_i);
    end

    regfile_array #(
        .DATA_W   (DATA_W),
        .NUM_REGS (NUM_REGS)
    ) u_array (
        .clk_i     (clk_i),
        .rst_i     (rst_i),
        .we_i      (wb_valid),
        .waddr_i   (RDaddr_i),
        .wdata_i   (wb_data),
        .raddr_a_i (RSaddr_i),
        .raddr_b_i (RTaddr_i),
        .rdata_a_o (raw_rs),
        .rdata_b_o (raw_rt)
    );

    // Read ports: same-cycle bypass of the committing write, then r0 masking.
    always_comb begin
        RSdata_o = raw_rs;
        RTdata_o = raw_rt;
        if (wb_valid && (RSaddr_i == RDaddr_i)) RSdata_o = wb_data;
        else if (RSaddr_i == ZERO_REG)          RSdata_o = '0;
        if (wb_valid && (RTaddr_i == RDaddr_i)) RTdata_o = wb_data;
        else if (RTaddr_i == ZERO_REG)          RTdata_o = '0;
    end

    // Retirement count advances once per committed write, wrapping naturally.
    always_comb begin
        retire_cnt_d = retire_cnt_q;
        if (wb_valid) retire_cnt_d = retire_cnt_q + 32'd1;
    end

    // Retirement counter register.
    always_ff @(posedge clk_i or negedge rst_i) begin
        if (!rst_i) retire_cnt_q <= '0;
        else        retire_cnt_q <= retire_cnt_d;
    end

    assign WBdata_o     = wb_data;
    assign WBvalid_o    = wb_valid;
    assign retire_cnt_o = retire_cnt_q;

endmodule

// File: tb/tb_writeback_regfile.sv
// Directed and randomized checks of writeback_regfile against a simple
// array-based reference model of the architectural register file.
module tb_writeback_regfile;

    logic        clk_i = 1'b0;
    logic        rst_i;
    logic        RegWrite_i;
    logic        MemtoReg_i;
    logic [31:0] Data1_i;
    logic [31:0] Data2_i;
    logic [4:0]  RDaddr_i;
    logic [4:0]  RSaddr_i;
    logic [4:0]  RTaddr_i;
    logic [31:0] RSdata_o;
    logic [31:0] RTdata_o;
    logic [31:0] WBdata_o;
    logic        WBvalid_o;
    logic [31:0] retire_cnt_o;

    int total = 0;
    int bad   = 0;

    logic [31:0] model_regs [32];
    logic [31:0] model_cnt;

    writeback_regfile dut (
        .clk_i        (clk_i),
        .rst_i        (rst_i),
        .RegWrite_i   (RegWrite_i),
        .MemtoReg_i   (MemtoReg_i),
        .Data1_i      (Data1_i),
        .Data2_i      (Data2_i),
        .RDaddr_i     (RDaddr_i),
        .RSaddr_i     (RSaddr_i),
        .RTaddr_i     (RTaddr_i),
        .RSdata_o     (RSdata_o),
        .RTdata_o     (RTdata_o),
        .WBdata_o     (WBdata_o),
        .WBvalid_o    (WBvalid_o),
        .retire_cnt_o (retire_cnt_o)
    );

    always #5 clk_i = ~clk_i;

    initial begin
        #2_000_000;
        $display("FAIL watchdog observed=timeout expected=finish");
        $fatal(1, "watchdog expired");
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic model_clear();
        for (int i = 0; i < 32; i++) model_regs[i] = '0;
        model_cnt = '0;
    endtask

    function automatic logic [31:0] exp_wb();
        return MemtoReg_i ? Data2_i : Data1_i;
    endfunction

    function automatic logic exp_valid();
        return RegWrite_i && (RDaddr_i != 5'd0);
    endfunction

    function automatic logic [31:0] exp_read(input logic [4:0] a);
        if (exp_valid() && a == RDaddr_i) return exp_wb();
        return model_regs[a];
    endfunction

    task automatic drive(input logic we, input logic m2r, input logic [31:0] d1,
                         input logic [31:0] d2, input logic [4:0] rd,
                         input logic [4:0] rs, input logic [4:0] rt);
        RegWrite_i = we;
        MemtoReg_i = m2r;
        Data1_i    = d1;
        Data2_i    = d2;
        RDaddr_i   = rd;
        RSaddr_i   = rs;
        RTaddr_i   = rt;
    endtask

    // Combinational outputs after inputs settle, before the next edge.
    task automatic check_comb(input string tag);
        #1;
        chk({tag, ".wbdata"}, WBdata_o, exp_wb());
        chk({tag, ".wbvalid"}, {31'd0, WBvalid_o}, {31'd0, exp_valid()});
        chk({tag, ".rs"}, RSdata_o, exp_read(RSaddr_i));
        chk({tag, ".rt"}, RTdata_o, exp_read(RTaddr_i));
        chk({tag, ".cnt"}, retire_cnt_o, model_cnt);
    endtask

    // Advance one clock, applying the architectural effect of the edge.
    task automatic tick();
        @(posedge clk_i);
        if (rst_i && RegWrite_i && RDaddr_i != 5'd0) begin
            model_regs[RDaddr_i] = MemtoReg_i ? Data2_i : Data1_i;
            model_cnt = model_cnt + 32'd1;
        end
        @(negedge clk_i);
    endtask

    initial begin
        rst_i = 1'b0;
        model_clear();
        drive(1'b0, 1'b0, '0, '0, 5'd0, 5'd0, 5'd5);

        // In reset: writes suppressed, reads and counter at zero.
        @(negedge clk_i);
        drive(1'b1, 1'b0, 32'h0000_00AA, '0, 5'd3, 5'd3, 5'd5);
        check_comb("in_reset_bypass");
        tick();
        drive(1'b0, 1'b0, '0, '0, 5'd0, 5'd3, 5'd5);
        check_comb("in_reset_nowrite");

        // Release reset and read addresses 0 and 5.
        rst_i = 1'b1;
        drive(1'b0, 1'b0, '0, '0, 5'd0, 5'd0, 5'd5);
        check_comb("post_reset");

        // ALU-result write to r5, then read it back.
        drive(1'b1, 1'b0, 32'h0000_1234, 32'h1111_1111, 5'd5, 5'd1, 5'd2);
        check_comb("alu_wr5");
        tick();
        drive(1'b0, 1'b0, '0, '0, 5'd0, 5'd5, 5'd5);
        check_comb("rd5");
        chk("rd5.literal", RSdata_o, 32'h0000_1234);
        chk("cnt1.literal", retire_cnt_o, 32'd1);

        // Memory-data write to r7 with both read ports bypassing.
        drive(1'b1, 1'b1, 32'h0BAD_0BAD, 32'hDEAD_BEEF, 5'd7, 5'd7, 5'd7);
        check_comb("mem_wr7_bypass");
        chk("bypass_rs.literal", RSdata_o, 32'hDEAD_BEEF);
        chk("bypass_rt.literal", RTdata_o, 32'hDEAD_BEEF);
        tick();

        // Write to r0 is discarded.
        drive(1'b1, 1'b0, 32'hFFFF_FFFF, '0, 5'd0, 5'd0, 5'd7);
        check_comb("wr0");
        tick();
        drive(1'b0, 1'b0, '0, '0, 5'd0, 5'd0, 5'd7);
        check_comb("after_wr0");
        chk("cnt_after_wr0.literal", retire_cnt_o, 32'd2);

        // Bubble with stale fields: no write, no count.
        drive(1'b0, 1'b0, 32'h0000_0055, '0, 5'd5, 5'd5, 5'd0);
        check_comb("bubble");
        tick();
        drive(1'b0, 1'b0, '0, '0, 5'd0, 5'd5, 5'd7);
        check_comb("after_bubble");

        // Back-to-back writes to the same register keep the last value.
        drive(1'b1, 1'b0, 32'hAAAA_0001, '0, 5'd9, 5'd9, 5'd1);
        check_comb("b2b_1");
        tick();
        drive(1'b1, 1'b1, '0, 32'hAAAA_0002, 5'd9, 5'd1, 5'd9);
        check_comb("b2b_2");
        tick();
        drive(1'b0, 1'b0, '0, '0, 5'd0, 5'd9, 5'd9);
        check_comb("b2b_read");

        // Randomized traffic.
        for (int n = 0; n < 400; n++) begin
            logic [4:0] rd;
            logic [4:0] rs;
            logic [4:0] rt;
            rd = ($urandom_range(0, 7) == 0) ? 5'd0 : 5'($urandom);
            rs = ($urandom_range(0, 3) == 0) ? rd : 5'($urandom);
            rt = ($urandom_range(0, 3) == 0) ? rd : 5'($urandom);
            drive(1'($urandom), 1'($urandom), $urandom, $urandom, rd, rs, rt);
            check_comb("rand");
            tick();
        end

        // Counter wrap: preload to all-ones, then one valid write.
        drive(1'b0, 1'b0, '0, '0, 5'd0, 5'd0, 5'd0);
        force dut.retire_cnt_q = 32'hFFFF_FFFF;
        #1;
        release dut.retire_cnt_q;
        model_cnt = 32'hFFFF_FFFF;
        check_comb("preload");
        drive(1'b1, 1'b0, 32'h0000_0077, '0, 5'd4, 5'd4, 5'd0);
        check_comb("wrap_wr");
        tick();
        drive(1'b0, 1'b0, '0, '0, 5'd0, 5'd4, 5'd0);
        check_comb("wrapped");
        chk("wrap.literal", retire_cnt_o, 32'd0);

        // Asynchronous reset mid-cycle clears everything at once.
        drive(1'b1, 1'b0, 32'h1357_9BDF, '0, 5'd9, 5'd4, 5'd9);
        check_comb("pre_async_rst");
        #1;
        rst_i = 1'b0;
        model_clear();
        RegWrite_i = 1'b0;
        for (int a = 1; a < 32; a += 2) begin
            RSaddr_i = 5'(a);
            RTaddr_i = 5'(a + 1);
            #1;
            chk("async_rst.rs", RSdata_o, 32'd0);
            chk("async_rst.rt", RTdata_o, 32'd0);
        end
        chk("async_rst.cnt", retire_cnt_o, 32'd0);

        // Write held across an edge during reset is dropped.
        @(negedge clk_i);
        drive(1'b1, 1'b0, 32'h2468_ACE0, '0, 5'd12, 5'd1, 5'd2);
        tick();
        drive(1'b0, 1'b0, '0, '0, 5'd0, 5'd12, 5'd0);
        check_comb("rst_drop");

        // First write lands on the first edge after release.
        rst_i = 1'b1;
        drive(1'b1, 1'b1, '0, 32'hCAFE_F00D, 5'd12, 5'd3, 5'd2);
        check_comb("first_wr");
        tick();
        drive(1'b0, 1'b0, '0, '0, 5'd0, 5'd12, 5'd3);
        check_comb("first_wr_read");
        chk("first_wr.literal", RSdata_o, 32'hCAFE_F00D);
        chk("first_wr_cnt.literal", retire_cnt_o, 32'd1);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
